operation_i_bw16_inc2_si0: RTL and testbench
============================================

// Module: operation_i_bw16_inc2_si0
// PURPOSE
//  Projection operation "I" of the Maltsev primitive-operation library.
//  On a start request it samples input number SI out of INC operand buses.
//  It returns that value unchanged on RES and raises RD.
//  The block is a leaf operator driven by a higher-level composition controller.
//  Controller protocol: pulse/hold ST, wait for RD, read RES.
// PARAMETERS
//  BW   16  operand/result bit width
//  INC  2   number of operand inputs (this variant: IN0, IN1)
//  SI   0   index of the selected input; 0 <= SI < INC, otherwise elaboration error
// PORTS
//  CLK  in   1   single clock, rising-edge
//  RST  in   1   asynchronous, active-low reset
//  ST   in   1   start request, level-sampled at CLK rise
//  RD   out  1   ready: RES valid
//  RES  out  BW  result = captured IN[SI]
//  IN0  in   BW  operand 0
//  IN1  in   BW  operand 1
// BEHAVIOUR
//  - Reset (RST=0, async): RD=0, RES=0, FSM=IDLE, applied immediately,
//    including mid-operation; held while RST=0.
//  - FSM states IDLE, DONE (registered; RD, RES are register outputs).
//  - IDLE, ST=1 at posedge:
//    - RES <= IN[SI] (IN0 when SI=0), RD <= 1, go to DONE.
//    - Latency: 1 clock from the ST-sampling edge to RD=1 with valid RES.
//  - IDLE, ST=0: hold; RD=0; RES keeps its last value.
//  - DONE, ST=1: hold RD=1 and RES.
//    - Operand changes are ignored, so there is no re-capture.
//  - DONE, ST=0 at posedge: RD <= 0, go to IDLE; RES retains the value.
//  - ST held high continuously gives exactly one capture.
//    - A new operation needs ST low for >=1 sampled edge, then high again.
//  - Non-selected inputs never affect RES.
//  - Pure copy: no arithmetic, no width change, no sign handling.
//  - Unknown/unused state encodings recover to IDLE with RD=0.
// TESTING
//  1. RST=0 for 2 cycles with ST=0, IN0=0, IN1=1 -> RD=0, RES=0x0000.
//  2. Release reset, IN0=0x0000, IN1=0x0001, ST=1
//     -> next edge: RD=1, RES=0x0000; stays so for 4 cycles with ST held.
//  3. IN0=0xA5A5, IN1=0x5A5A, ST 0->1 -> RD=1 after 1 clock, RES=0xA5A5.
//     - Then IN0 changes to 0x1234 with ST still 1 -> RES stays 0xA5A5.
//  4. ST=0 for 1 cycle -> RD=0, RES=0xA5A5.
//     - Then IN0=0xFFFF, ST=1 -> RD=1, RES=0xFFFF.
//  5. Assert RST=0 mid-cycle while RD=1 -> RD=0 and RES=0 immediately,
//     without waiting for a clock edge.
//  6. Elaborate with SI=1, IN0=0, IN1=0x0001, ST=1 -> RES=0x0001, RD=1.
//     - Elaborating with SI=2 must fail.

Source files
------------

// File: rtl/operation_i_bw16_inc2_si0.sv
// operation_i_bw16_inc2_si0: projection operator, captures input SI on start and presents it with a ready flag
module operation_i_bw16_inc2_si0 #(
    parameter int BW  = 16,
    parameter int INC = 2,
    parameter int SI  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st,
    output logic          rd,
    output logic [BW-1:0] res,
    input  logic [BW-1:0] in0,
    input  logic [BW-1:0] in1
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DONE = 2'b01
    } state_t;

    generate
        if (INC != 2) begin : g_bad_inc
            $error("operation_i_bw16_inc2_si0: INC must be 2 (ports in0, in1)");
        end
        if (SI < 0 || SI >= INC) begin : g_bad_si
            $error("operation_i_bw16_inc2_si0: SI must satisfy 0 <= SI < INC");
        end
    endgenerate

    state_t        state;
    state_t        next_state;
    logic          capture;
    logic [BW-1:0] sel;

    assign sel = (SI == 0) ? in0 : in1;

    // next state: both legal states follow st, so one capture per st high period; stray encodings fall back to IDLE
    always_comb begin
        next_state = IDLE;
        capture    = 1'b0;
        if (state == IDLE || state == DONE) next_state = st ? DONE : IDLE;
        capture = (state == IDLE) && st;
    end

    // state, ready and result registers; result only loads on the IDLE->DONE transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rd    <= 1'b0;
            res   <= '0;
        end else begin
            state <= next_state;
            rd    <= (next_state == DONE);
            if (capture) res <= sel;
        end
    end
endmodule

// File: tb/tb_operation_i_bw16_inc2_si0.sv
// tb_operation_i_bw16_inc2_si0: directed checks of the projection operator for SI=0 and SI=1
module tb_operation_i_bw16_inc2_si0;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        st;
    logic [15:0] in0;
    logic [15:0] in1;
    logic        rd0, rd1;
    logic [15:0] res0, res1;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    operation_i_bw16_inc2_si0 #(.BW(16), .INC(2), .SI(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .st(st), .rd(rd0), .res(res0), .in0(in0), .in1(in1)
    );

    operation_i_bw16_inc2_si0 #(.BW(16), .INC(2), .SI(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .st(st), .rd(rd1), .res(res1), .in0(in0), .in1(in1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; st = 1'b0; in0 = 16'h0000; in1 = 16'h0001;
        step(); step();
        checks++;
        if (rd0 !== 1'b0) begin errors++; $display("FAIL reset_rd0 got %b want 0", rd0); end
        checks++;
        if (res0 !== 16'h0000) begin errors++; $display("FAIL reset_res0 got %h want 0000", res0); end
        checks++;
        if (res1 !== 16'h0000) begin errors++; $display("FAIL reset_res1 got %h want 0000", res1); end
    endtask

    task automatic test_first_capture();
        rst_n = 1'b1; in0 = 16'h0000; in1 = 16'h0001; st = 1'b1;
        #1;
        checks++;
        if (rd0 !== 1'b0) begin errors++; $display("FAIL pre_edge_rd got %b want 0", rd0); end
        step();
        checks++;
        if (rd0 !== 1'b1 || res0 !== 16'h0000) begin errors++; $display("FAIL first_cap si0 got rd=%b res=%h want rd=1 res=0000", rd0, res0); end
        checks++;
        if (rd1 !== 1'b1 || res1 !== 16'h0001) begin errors++; $display("FAIL first_cap si1 got rd=%b res=%h want rd=1 res=0001", rd1, res1); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (rd0 !== 1'b1 || res0 !== 16'h0000) begin errors++; $display("FAIL hold_%0d got rd=%b res=%h want rd=1 res=0000", i, rd0, res0); end
        end
    endtask

    task automatic test_capture_ignore();
        st = 1'b0;
        step();
        checks++;
        if (rd0 !== 1'b0) begin errors++; $display("FAIL drop_rd got %b want 0", rd0); end
        in0 = 16'hA5A5; in1 = 16'h5A5A; st = 1'b1;
        step();
        checks++;
        if (rd0 !== 1'b1 || res0 !== 16'hA5A5) begin errors++; $display("FAIL cap_a5 got rd=%b res=%h want rd=1 res=a5a5", rd0, res0); end
        checks++;
        if (res1 !== 16'h5A5A) begin errors++; $display("FAIL cap_5a_si1 got %h want 5a5a", res1); end
        in0 = 16'h1234;
        step(); step();
        checks++;
        if (rd0 !== 1'b1 || res0 !== 16'hA5A5) begin errors++; $display("FAIL no_recapture got rd=%b res=%h want rd=1 res=a5a5", rd0, res0); end
    endtask

    task automatic test_back_to_back();
        st = 1'b0;
        step();
        checks++;
        if (rd0 !== 1'b0 || res0 !== 16'hA5A5) begin errors++; $display("FAIL idle_keep got rd=%b res=%h want rd=0 res=a5a5", rd0, res0); end
        in0 = 16'hFFFF; st = 1'b1;
        step();
        checks++;
        if (rd0 !== 1'b1 || res0 !== 16'hFFFF) begin errors++; $display("FAIL cap_ffff got rd=%b res=%h want rd=1 res=ffff", rd0, res0); end
        checks++;
        if (res1 !== 16'h5A5A) begin errors++; $display("FAIL si1_unsel got %h want 5a5a", res1); end
    endtask

    task automatic test_async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd0 !== 1'b0 || res0 !== 16'h0000) begin errors++; $display("FAIL async_rst got rd=%b res=%h want rd=0 res=0000", rd0, res0); end
        checks++;
        if (rd1 !== 1'b0 || res1 !== 16'h0000) begin errors++; $display("FAIL async_rst_si1 got rd=%b res=%h want rd=0 res=0000", rd1, res1); end
        step();
        checks++;
        if (rd0 !== 1'b0) begin errors++; $display("FAIL rst_held got %b want 0", rd0); end
        rst_n = 1'b1; st = 1'b0; in0 = 16'h0F0F;
        step();
        st = 1'b1;
        step();
        checks++;
        if (rd0 !== 1'b1 || res0 !== 16'h0F0F) begin errors++; $display("FAIL post_rst_cap got rd=%b res=%h want rd=1 res=0f0f", rd0, res0); end
    endtask

    initial begin
        test_reset();
        test_first_capture();
        test_capture_ignore();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
